// File: rtl/reg_file_onehot.sv
// ---------------------------------------------------------------------------
// reg_file_onehot
//   NREG x DATA_W register bank driven by one-hot read/write select vectors.
//   - Read data is registered: a ONE read in cycle N shows up in cycle N+1.
//   - A multi-hot (MULTI) select on either vector blocks that access. It also
//     sets a sticky error flag and bumps a saturating error counter.
//   - Register 0 is exported continuously as the accumulator.
//   Build option: define REG_FILE_WR_BYPASS_EN so that a same-cycle write and
//   read of one register returns the new data. Otherwise the old data is
//   returned.
// ---------------------------------------------------------------------------
module reg_file_onehot #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned NREG      = 8,
   parameter int unsigned ERR_CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREG-1:0]      x_write_en,
   input  logic [NREG-1:0]      x_read_en,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 err_clr,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 rd_valid,
   output logic [DATA_W-1:0]    acc_data,
   output logic                 onehot_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

   // Two or more bits set. Clearing the lowest set bit leaves a nonzero
   // remainder only for multi-hot vectors.
   function automatic logic is_multi(input logic [NREG-1:0] v);
      return |(v & (v - NREG'(1)));
   endfunction

   logic [DATA_W-1:0]    regs_q [NREG];
   logic [DATA_W-1:0]    regs_d [NREG];
   logic [DATA_W-1:0]    rd_data_q, rd_data_d;
   logic                 rd_valid_q, rd_valid_d;
   logic                 onehot_err_q, onehot_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic                 wr_one, wr_multi;
   logic                 rd_one, rd_multi;
   logic                 err_event;
   logic [DATA_W-1:0]    rd_word;

   // Classify both select vectors as ZERO / ONE / MULTI.
   always_comb begin
      wr_multi  = is_multi(x_write_en);
      rd_multi  = is_multi(x_read_en);
      wr_one    = (|x_write_en) && !wr_multi;
      rd_one    = (|x_read_en)  && !rd_multi;
      err_event = wr_multi || rd_multi;
   end

   // Next-state for the register array, read path and error tracking.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      regs_d       = regs_q;
      rd_word      = '0;
      rd_data_d    = rd_data_q;
      rd_valid_d   = 1'b0;
      onehot_err_d = onehot_err_q;
      err_cnt_d    = err_cnt_q;

      // A ONE write updates only the selected word. A MULTI write is dropped.
      if (wr_one) begin
         for (int i = 0; i < NREG; i++) begin
            if (x_write_en[i]) regs_d[i] = wr_data;
         end
      end

      // AND-OR mux. The select is known to be one-hot wherever this is used.
      for (int i = 0; i < NREG; i++) begin
         if (x_read_en[i]) rd_word = rd_word | regs_q[i];
      end
`ifdef REG_FILE_WR_BYPASS_EN
      // Write-through: the same register written and read returns new data.
      if (wr_one && rd_one && (x_write_en == x_read_en)) rd_word = wr_data;
`endif

      if (rd_one) begin
         rd_data_d  = rd_word;
         rd_valid_d = 1'b1;
      end

      // A MULTI on both vectors is a single event. An event outranks err_clr,
      // so a clear in the same cycle restarts the count at one.
      if (err_event) begin
         onehot_err_d = 1'b1;
         if (err_clr)                       err_cnt_d = ERR_CNT_W'(1);
         else if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end else if (err_clr) begin
         onehot_err_d = 1'b0;
         err_cnt_d    = '0;
      end
   end

   // State registers. The asynchronous reset clears everything, including any
   // read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage array is reset too, because reads after reset must return zero.
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         onehot_err_q <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
         regs_q       <= regs_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         onehot_err_q <= onehot_err_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign acc_data   = regs_q[0];
   assign onehot_err = onehot_err_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_reg_file_onehot.sv
// ---------------------------------------------------------------------------
// tb_reg_file_onehot
//   Applies a table of directed vectors, then hand-written multi-cycle
//   sequences, then randomized traffic. The randomized traffic is compared
//   against a behavioural model of the register bank.
// ---------------------------------------------------------------------------
module tb_reg_file_onehot;

   localparam int DW = 8;
   localparam int NR = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] x_write_en, x_read_en;
   logic [DW-1:0] wr_data;
   logic          err_clr;
   logic [DW-1:0] rd_data, acc_data;
   logic          rd_valid, onehot_err;
   logic [CW-1:0] err_cnt;

   int checks = 0;
   int errors = 0;

`ifdef REG_FILE_WR_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   reg_file_onehot #(.DATA_W(DW), .NREG(NR), .ERR_CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .x_write_en (x_write_en),
      .x_read_en  (x_read_en),
      .wr_data    (wr_data),
      .err_clr    (err_clr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .acc_data   (acc_data),
      .onehot_err (onehot_err),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_regs [NR];
   logic [DW-1:0] m_rd;
   logic          m_valid;
   logic          m_err;
   int            m_cnt;

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_rd = '0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
   endtask

   task automatic model_step(input logic [NR-1:0] we, input logic [NR-1:0] re,
                             input logic [DW-1:0] wd, input logic clr);
      int wc = $countones(we);
      int rc = $countones(re);
      if (rc == 1) begin
         m_rd    = (BYPASS && wc == 1 && we == re) ? wd : m_regs[$clog2(re)];
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      if (wc == 1) m_regs[$clog2(we)] = wd;
      if (wc > 1 || rc > 1) begin
         m_err = 1'b1;
         m_cnt = clr ? 1 : ((m_cnt + 1 > 15) ? 15 : m_cnt + 1);
      end else if (clr) begin
         m_err = 1'b0;
         m_cnt = 0;
      end
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, and leave time at edge+1.
   task automatic step(input logic [NR-1:0] we, input logic [NR-1:0] re,
                       input logic [DW-1:0] wd, input logic clr);
      x_write_en = we; x_read_en = re; wr_data = wd; err_clr = clr;
      model_step(we, re, wd, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, " rd_data"},  32'(rd_data),    32'(m_rd));
      check({tag, " rd_valid"}, 32'(rd_valid),   32'(m_valid));
      check({tag, " acc_data"}, 32'(acc_data),   32'(m_regs[0]));
      check({tag, " err"},      32'(onehot_err), 32'(m_err));
      check({tag, " cnt"},      32'(err_cnt),    32'(m_cnt));
   endtask

   task automatic do_reset();
      x_write_en = '0; x_read_en = '0; wr_data = '0; err_clr = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [NR-1:0] we;
      logic [NR-1:0] re;
      logic [DW-1:0] wd;
      logic          clr;
      logic [DW-1:0] e_rd;
      logic          e_v;
      logic [DW-1:0] e_acc;
      logic          e_err;
      logic [CW-1:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [NR-1:0] we, logic [NR-1:0] re, logic [DW-1:0] wd,
                               logic clr, logic [DW-1:0] e_rd, logic e_v,
                               logic [DW-1:0] e_acc, logic e_err, logic [CW-1:0] e_cnt);
      vec_t v;
      v.we = we; v.re = re; v.wd = wd; v.clr = clr;
      v.e_rd = e_rd; v.e_v = e_v; v.e_acc = e_acc; v.e_err = e_err; v.e_cnt = e_cnt;
      return v;
   endfunction

   initial begin
      logic [NR-1:0] one;
      logic [DW-1:0] exp_byp;

      // Read every register after reset: all zero.
      for (int i = 0; i < NR; i++) begin
         one = NR'(1) << i;
         vecs.push_back(mk('0, one, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 4'd0));
      end
      // Write 0x10+i to reg i. acc follows reg 0 from the first write on.
      for (int i = 0; i < NR; i++) begin
         one = NR'(1) << i;
         vecs.push_back(mk(one, '0, 8'(8'h10 + i), 1'b0, 8'h00, 1'b0, 8'h10, 1'b0, 4'd0));
      end
      // Back-to-back readback.
      for (int i = 0; i < NR; i++) begin
         one = NR'(1) << i;
         vecs.push_back(mk('0, one, 8'h00, 1'b0, 8'(8'h10 + i), 1'b1, 8'h10, 1'b0, 4'd0));
      end
      // Idle: rd_data holds, rd_valid drops.
      vecs.push_back(mk(8'h00, 8'h00, 8'h33, 1'b0, 8'h17, 1'b0, 8'h10, 1'b0, 4'd0));
      // MULTI write: no change, error event.
      vecs.push_back(mk(8'h05, 8'h00, 8'hFF, 1'b0, 8'h17, 1'b0, 8'h10, 1'b1, 4'd1));
      vecs.push_back(mk(8'h00, 8'h01, 8'h00, 1'b0, 8'h10, 1'b1, 8'h10, 1'b1, 4'd1));
      vecs.push_back(mk(8'h00, 8'h04, 8'h00, 1'b0, 8'h12, 1'b1, 8'h10, 1'b1, 4'd1));
      // MULTI read: rd_valid=0, data holds, event.
      vecs.push_back(mk(8'h00, 8'h03, 8'h00, 1'b0, 8'h12, 1'b0, 8'h10, 1'b1, 4'd2));
      // MULTI on both vectors counts once.
      vecs.push_back(mk(8'h03, 8'h0C, 8'hEE, 1'b0, 8'h12, 1'b0, 8'h10, 1'b1, 4'd3));
      // Clear and event together: the event wins, so the count restarts at 1.
      vecs.push_back(mk(8'h06, 8'h00, 8'h00, 1'b1, 8'h12, 1'b0, 8'h10, 1'b1, 4'd1));
      // Clear alone.
      vecs.push_back(mk(8'h00, 8'h00, 8'h00, 1'b1, 8'h12, 1'b0, 8'h10, 1'b0, 4'd0));
      // Write reg5 while reading reg6: no interaction.
      vecs.push_back(mk(8'h20, 8'h40, 8'h55, 1'b0, 8'h16, 1'b1, 8'h10, 1'b0, 4'd0));
      vecs.push_back(mk(8'h00, 8'h20, 8'h00, 1'b0, 8'h55, 1'b1, 8'h10, 1'b0, 4'd0));
      // Earlier MULTI writes left regs 0..3 alone.
      vecs.push_back(mk(8'h00, 8'h02, 8'h00, 1'b0, 8'h11, 1'b1, 8'h10, 1'b0, 4'd0));
      vecs.push_back(mk(8'h00, 8'h08, 8'h00, 1'b0, 8'h13, 1'b1, 8'h10, 1'b0, 4'd0));

      do_reset();
      #1;
      check("reset rd_data",  32'(rd_data),    32'h0);
      check("reset rd_valid", 32'(rd_valid),   32'h0);
      check("reset acc_data", 32'(acc_data),   32'h0);
      check("reset err",      32'(onehot_err), 32'h0);
      check("reset cnt",      32'(err_cnt),    32'h0);

      foreach (vecs[k]) begin
         step(vecs[k].we, vecs[k].re, vecs[k].wd, vecs[k].clr);
         check($sformatf("vec%0d rd_data", k),  32'(rd_data),    32'(vecs[k].e_rd));
         check($sformatf("vec%0d rd_valid", k), 32'(rd_valid),   32'(vecs[k].e_v));
         check($sformatf("vec%0d acc_data", k), 32'(acc_data),   32'(vecs[k].e_acc));
         check($sformatf("vec%0d err", k),      32'(onehot_err), 32'(vecs[k].e_err));
         check($sformatf("vec%0d cnt", k),      32'(err_cnt),    32'(vecs[k].e_cnt));
      end

      // ---- saturation: 1 event, then 20 more -> 15 ----
      step(8'h05, 8'h00, 8'hFF, 1'b0);
      check("sat first cnt", 32'(err_cnt), 32'd1);
      check("sat first err", 32'(onehot_err), 32'd1);
      for (int i = 0; i < 20; i++) step(8'h00, 8'hF0, 8'h00, 1'b0);
      check("sat cnt", 32'(err_cnt), 32'd15);
      check("sat err", 32'(onehot_err), 32'd1);
      step(8'h00, 8'h00, 8'h00, 1'b1);
      check("clr cnt", 32'(err_cnt), 32'd0);
      check("clr err", 32'(onehot_err), 32'd0);

      // ---- same-register write+read ----
      step(8'h10, 8'h00, 8'h44, 1'b0);
      step(8'h10, 8'h10, 8'hAB, 1'b0);
      exp_byp = BYPASS ? 8'hAB : 8'h44;
      check("same-reg rd_data", 32'(rd_data), 32'(exp_byp));
      check("same-reg rd_valid", 32'(rd_valid), 32'd1);
      step(8'h00, 8'h10, 8'h00, 1'b0);
      check("same-reg next read", 32'(rd_data), 32'hAB);

      // ---- reset mid-read ----
      step(8'h02, 8'h00, 8'h5A, 1'b0);
      step(8'h00, 8'h02, 8'h00, 1'b0);
      check("pre-reset rd_data", 32'(rd_data), 32'h5A);
      check("pre-reset rd_valid", 32'(rd_valid), 32'd1);
      x_read_en = 8'h02;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async rst rd_valid", 32'(rd_valid), 32'd0);
      check("async rst rd_data",  32'(rd_data),  32'h0);
      check("async rst acc",      32'(acc_data), 32'h0);
      @(posedge clk);
      #1;
      check("held rst rd_valid", 32'(rd_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h00, 8'h02, 8'h00, 1'b0);
      check("post-reset reg1", 32'(rd_data), 32'h0);
      check("post-reset valid", 32'(rd_valid), 32'd1);

      // ---- randomized traffic vs model ----
      for (int n = 0; n < 400; n++) begin
         logic [NR-1:0] we, re;
         int kind;
         kind = $urandom_range(0, 7);
         we = (kind == 0) ? '0 : (kind == 7) ? NR'($urandom) : NR'(1) << $urandom_range(0, NR - 1);
         kind = $urandom_range(0, 7);
         re = (kind == 0) ? '0 : (kind == 7) ? NR'($urandom) : NR'(1) << $urandom_range(0, NR - 1);
         if ($urandom_range(0, 7) == 0) re = we;
         step(we, re, DW'($urandom), ($urandom_range(0, 15) == 0));
         check_model($sformatf("rand%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
